// File: rtl/dashcam_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dashcam_pkg
// Description : Shared types for the camera ingress path (packer state, FIFO entry).
// Revision    : 1.0
// ============================================================================
package dashcam_pkg;

  localparam int CAM_WORD_W = 32;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } cam_pack_state_e;

  typedef struct packed {
    logic [CAM_WORD_W-1:0] data;
    logic [3:0]            be;
    logic                  last;
  } cam_fifo_entry_t;

  // Byte enables for lanes 0..lane inclusive.
  function automatic logic [3:0] be_upto(input logic [1:0] lane);
    return {lane == 2'd3, lane >= 2'd2, lane >= 2'd1, 1'b1};
  endfunction

  // Byte enables for the first n lanes (n = 0..3).
  function automatic logic [3:0] be_below(input logic [1:0] n);
    return {1'b0, n == 2'd3, n >= 2'd2, n >= 2'd1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cam_word_fifo
// Description : Synchronous first-word-fall-through FIFO of packed word entries.
// Revision    : 1.0
// ============================================================================
module cam_word_fifo
  import dashcam_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  cam_fifo_entry_t wr_entry,
  input  logic            pop,
  output cam_fifo_entry_t rd_entry,
  output logic            full,
  output logic            empty,
  output logic            dropped
);

  localparam int AW = $clog2(DEPTH);

  cam_fifo_entry_t r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            w_do_pop;
  logic            w_do_push;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full-FIFO push writes into.
  assign w_do_push = push & (~full | w_do_pop);
  assign dropped   = push & ~w_do_push;
  assign rd_entry  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= wr_entry;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cam_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : cam_pixel_packer
// Description : Packs camera bytes into 32-bit words per frame for the DMA.
//               Define CAM_PACKER_CSUM_EN to add the frame_csum output.
// Revision    : 1.0
// ============================================================================
module cam_pixel_packer
  import dashcam_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CNT_W-1:0]      frame_bytes,
  input  logic                  cam_valid,
  input  logic                  cam_sof,
  input  logic [7:0]            cam_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CAM_WORD_W-1:0] out_data,
  output logic [3:0]            out_be,
  output logic                  out_last,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_count,
  output logic                  overflow,
  output logic                  short_frame,
  input  logic                  status_clr,
  output logic                  busy
`ifdef CAM_PACKER_CSUM_EN
  ,
  output logic [15:0]           frame_csum
`endif
);

  cam_pack_state_e       r_state;
  cam_pack_state_e       w_state_n;
  logic [CNT_W-1:0]      r_size;
  logic [CNT_W-1:0]      w_size_n;
  logic [CNT_W-1:0]      r_byte_cnt;
  logic [CNT_W-1:0]      w_byte_cnt_n;
  logic [CAM_WORD_W-1:0] r_word;
  logic [CAM_WORD_W-1:0] w_word_n;
  logic [CAM_WORD_W-1:0] w_word_cur;
  logic [1:0]            w_lane;
  logic                  w_last_byte;
  logic                  w_sof_go;
  logic                  w_start;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_push;
  cam_fifo_entry_t       w_entry;
  cam_fifo_entry_t       w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic                  r_frame_done;
  logic [CNT_W-1:0]      r_frame_count;
  logic                  r_overflow;
  logic                  r_short_frame;

  assign w_sof_go    = en & cam_valid & cam_sof & (frame_bytes != '0);
  assign w_lane      = r_byte_cnt[1:0];
  assign w_last_byte = ((r_byte_cnt + CNT_W'(1)) == r_size);

  always_comb begin
    w_word_cur                         = r_word;
    w_word_cur[{w_lane, 3'b000} +: 8] = cam_pixel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_size_n     = r_size;
    w_byte_cnt_n = r_byte_cnt;
    w_word_n     = r_word;
    w_push       = 1'b0;
    w_entry      = '0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_sof_go) begin
          w_start = 1'b1;
        end
      end
      CAPTURE: begin
        if (!en) begin
          w_state_n = IDLE;
          w_word_n  = '0;
        end else if (w_sof_go) begin
          w_abort = 1'b1;
          w_push  = 1'b1;
          w_entry = '{data: r_word, be: be_below(w_lane), last: 1'b1};
          w_start = 1'b1;
        end else if (cam_valid) begin
          w_byte_cnt_n = r_byte_cnt + CNT_W'(1);
          if ((w_lane == 2'd3) || w_last_byte) begin
            w_push   = 1'b1;
            w_entry  = '{data: w_word_cur, be: be_upto(w_lane), last: w_last_byte};
            w_word_n = '0;
          end else begin
            w_word_n = w_word_cur;
          end
          if (w_last_byte) begin
            w_done    = 1'b1;
            w_state_n = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase

    // A one-byte frame completes on its SOF; if that SOF also aborted a frame,
    // the single push port carries the completed word and the abort marker is lost.
    if (w_start) begin
      w_size_n     = frame_bytes;
      w_byte_cnt_n = CNT_W'(1);
      if (frame_bytes == CNT_W'(1)) begin
        w_push    = 1'b1;
        w_entry   = '{data: CAM_WORD_W'(cam_pixel), be: 4'h1, last: 1'b1};
        w_word_n  = '0;
        w_done    = 1'b1;
        w_state_n = IDLE;
      end else begin
        w_word_n  = CAM_WORD_W'(cam_pixel);
        w_state_n = CAPTURE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_size        <= '0;
      r_byte_cnt    <= '0;
      r_word        <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_overflow    <= 1'b0;
      r_short_frame <= 1'b0;
    end else begin
      r_size        <= w_size_n;
      r_byte_cnt    <= w_byte_cnt_n;
      r_word        <= w_word_n;
      r_frame_done  <= w_done;
      if (w_done) begin
        r_frame_count <= r_frame_count + CNT_W'(1);
      end
      r_overflow    <= w_drop | (r_overflow & ~status_clr);
      r_short_frame <= w_abort | (r_short_frame & ~status_clr);
    end
  end

  cam_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .wr_entry (w_entry),
    .pop      (out_ready),
    .rd_entry (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .dropped  (w_drop)
  );

  assign out_valid   = ~w_empty;
  assign out_data    = w_head.data;
  assign out_be      = w_head.be;
  assign out_last    = w_head.last;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign overflow    = r_overflow;
  assign short_frame = r_short_frame;
  assign busy        = (r_state == CAPTURE);

`ifdef CAM_PACKER_CSUM_EN
  logic [15:0] r_sum;
  logic [15:0] w_sum_n;
  logic [15:0] r_frame_csum;
  logic        w_byte;

  assign w_byte = (r_state == CAPTURE) & en & cam_valid & ~w_sof_go;

  always_comb begin
    w_sum_n = r_sum;
    if (w_start) begin
      w_sum_n = 16'(cam_pixel);
    end else if (w_byte) begin
      w_sum_n = r_sum + 16'(cam_pixel);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum        <= '0;
      r_frame_csum <= '0;
    end else begin
      r_sum <= w_sum_n;
      if (w_done) begin
        r_frame_csum <= w_sum_n;
      end
    end
  end

  assign frame_csum = r_frame_csum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_pixel_packer
// Description : Self-checking bench for cam_pixel_packer (CAM_PACKER_CSUM_EN aware).
// Revision    : 1.0
// ============================================================================
module tb_cam_pixel_packer;
  import dashcam_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, cam_valid, cam_sof, out_ready, status_clr;
  logic [15:0] frame_bytes;
  logic [7:0]  cam_pixel;
  logic        out_valid, out_last, frame_done, overflow, short_frame, busy;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic [15:0] frame_count;
`ifdef CAM_PACKER_CSUM_EN
  logic [15:0] frame_csum;
`endif

  always #5 clk = ~clk;

  cam_pixel_packer #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .frame_bytes(frame_bytes),
    .cam_valid(cam_valid), .cam_sof(cam_sof), .cam_pixel(cam_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_be(out_be), .out_last(out_last), .frame_done(frame_done),
    .frame_count(frame_count), .overflow(overflow), .short_frame(short_frame),
    .status_clr(status_clr), .busy(busy)
`ifdef CAM_PACKER_CSUM_EN
    , .frame_csum(frame_csum)
`endif
  );

  int n_pass = 0, n_total = 0, done_cnt = 0;
  cam_fifo_entry_t got_q[$], exp_q[$];
  logic            stall_d = 1'b0;
  cam_fifo_entry_t stall_e;
  logic [7:0]      pix [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Observes the DUT away from the driving edge: accepted words, pulses, stall hold.
  always @(negedge clk) begin
    if (rst) begin
      stall_d = 1'b0;
    end else begin
      if (stall_d && out_valid)
        check("stall_hold", {out_data, out_be, out_last}, stall_e);
      if (out_valid && out_ready)
        got_q.push_back('{data: out_data, be: out_be, last: out_last});
      if (frame_done) done_cnt++;
      stall_d = out_valid && !out_ready;
      stall_e = '{data: out_data, be: out_be, last: out_last};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic sof, input logic [7:0] p);
    cam_valid = 1'b1; cam_sof = sof; cam_pixel = p;
    step();
    cam_valid = 1'b0; cam_sof = 1'b0;
  endtask

  task automatic send_frame(input int size, input logic [7:0] base, input int n);
    frame_bytes = 16'(size);
    for (int i = 0; i < n; i++) drive_byte(i == 0, base + 8'(i));
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while (out_valid && k < 200) begin step(); k++; end
    step();
    check("drain_timeout", 64'(k < 200), 64'd1);
  endtask

  // Reference: expected words of a frame of `size` bytes of which `k` were sent.
  task automatic model_frame(input int k, input int size);
    int nw = (k + 3) / 4;
    logic complete = (k == size);
    for (int w = 0; w < nw; w++) begin
      int cnt = (k - 4*w >= 4) ? 4 : k - 4*w;
      logic [31:0] d = 0;
      for (int l = 0; l < cnt; l++) d = d | (32'(pix[4*w+l]) << (8*l));
      exp_q.push_back('{data: d, be: 4'((1 << cnt) - 1),
                        last: (w == nw-1) && (complete || cnt < 4)});
    end
    if (!complete && (k % 4 == 0)) exp_q.push_back('{data: 32'h0, be: 4'h0, last: 1'b1});
  endtask

  typedef struct {
    int          size;
    logic [7:0]  base;
    int          nwords;
    logic [31:0] w0;
    logic [3:0]  be0;
    logic [31:0] wl;
    logic [3:0]  bel;
  } vec_t;

  vec_t vecs[5];
  int   exp_fc, d0, exp_done, size, k;
  logic aborted_any, prev_complete;
  logic [15:0] exp_csum;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64, 8'h00, 16, 32'h03020100, 4'hF, 32'h3F3E3D3C, 4'hF};
    vecs[1] = '{ 6, 8'hA0,  2, 32'hA3A2A1A0, 4'hF, 32'h0000A5A4, 4'h3};
    vecs[2] = '{ 1, 8'h5A,  1, 32'h0000005A, 4'h1, 32'h0000005A, 4'h1};
    vecs[3] = '{ 7, 8'h10,  2, 32'h13121110, 4'hF, 32'h00161514, 4'h7};
    vecs[4] = '{ 4, 8'hC0,  1, 32'hC3C2C1C0, 4'hF, 32'hC3C2C1C0, 4'hF};

    rst = 1; en = 0; cam_valid = 0; cam_sof = 0; cam_pixel = 0;
    frame_bytes = 0; out_ready = 0; status_clr = 0;
    repeat (3) step();
    rst = 0;
    step();

    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_be", out_be, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_short_frame", short_frame, 0);
    check("rst_busy", busy, 0);
`ifdef CAM_PACKER_CSUM_EN
    check("rst_frame_csum", frame_csum, 0);
`endif

    en = 1; out_ready = 1; exp_fc = 0;
    // Table: complete frames with out_ready held high.
    for (int i = 0; i < 5; i++) begin
      got_q.delete();
      d0 = done_cnt;
      send_frame(vecs[i].size, vecs[i].base, vecs[i].size);
      check("done_pulse", frame_done, 1);
      check("valid_after_push", out_valid, 1);
      drain();
      exp_fc++;
      check("tbl_nwords", got_q.size(), vecs[i].nwords);
      if (got_q.size() == vecs[i].nwords) begin
        check("tbl_w0_data", got_q[0].data, vecs[i].w0);
        check("tbl_w0_be", got_q[0].be, vecs[i].be0);
        check("tbl_wl_data", got_q[$].data, vecs[i].wl);
        check("tbl_wl_be", got_q[$].be, vecs[i].bel);
        check("tbl_wl_last", got_q[$].last, 1);
      end
      check("tbl_done_cnt", done_cnt - d0, 1);
      check("tbl_frame_count", frame_count, 16'(exp_fc));
`ifdef CAM_PACKER_CSUM_EN
      if (i == 0) check("csum_0_63", frame_csum, 16'h07E0);
`endif
    end

    // Early SOF aborts a 64-byte frame after 5 bytes.
    got_q.delete(); d0 = done_cnt;
    send_frame(64, 8'h00, 5);
    check("abort_busy", busy, 1);
    frame_bytes = 16'd8;
    drive_byte(1'b1, 8'h80);
    check("abort_short", short_frame, 1);
    check("abort_count_hold", frame_count, 16'(exp_fc));
    for (int i = 1; i < 8; i++) drive_byte(1'b0, 8'h80 + 8'(i));
    drain();
    exp_fc++;
    check("abort_nwords", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("abort_w0", got_q[0], {32'h03020100, 4'hF, 1'b0});
      check("abort_w1", got_q[1], {32'h00000004, 4'h1, 1'b1});
      check("abort_w3", got_q[3], {32'h87868584, 4'hF, 1'b1});
    end
    check("abort_count", frame_count, 16'(exp_fc));
    check("abort_done_cnt", done_cnt - d0, 1);
    status_clr = 1; step(); status_clr = 0;
    check("short_clr", short_frame, 0);

    // Back-pressure: 64-byte frame into an 8-deep FIFO that is not drained.
    got_q.delete();
    out_ready = 0;
    send_frame(64, 8'h00, 64);
    step();
    check("ovf_set", overflow, 1);
    check("ovf_count", frame_count, 16'(exp_fc + 1));
    check("ovf_head", out_data, 32'h03020100);
    check("ovf_no_short", short_frame, 0);
    exp_fc++;
    status_clr = 1; step(); status_clr = 0;
    check("ovf_clr", overflow, 0);
    drain();
    check("ovf_nwords", got_q.size(), 8);
    if (got_q.size() == 8) check("ovf_w7", got_q[7], {32'h1F1E1D1C, 4'hF, 1'b0});

    // Capture enable dropped mid-frame.
    got_q.delete();
    send_frame(64, 8'h00, 10);
    en = 0; step();
    check("en_drop_busy", busy, 0);
    en = 1;
    send_frame(4, 8'hD0, 4);
    drain();
    exp_fc++;
    check("en_nwords", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("en_w0", got_q[0], {32'h03020100, 4'hF, 1'b0});
      check("en_w1", got_q[1], {32'h07060504, 4'hF, 1'b0});
      check("en_w2", got_q[2], {32'hD3D2D1D0, 4'hF, 1'b1});
    end
    check("en_count", frame_count, 16'(exp_fc));
    check("en_no_short", short_frame, 0);

    // Randomized frames with gaps, aborts, junk idle bytes and random out_ready.
    got_q.delete(); exp_q.delete();
    d0 = done_cnt; exp_done = 0; aborted_any = 0; prev_complete = 1; exp_csum = 0;
    for (int f = 0; f < 40; f++) begin
      size = $urandom_range(2, 24);
      k = (f != 39 && $urandom_range(0, 3) == 0) ? $urandom_range(1, size - 1) : size;
      for (int i = 0; i < k; i++) pix[i] = 8'($urandom);
      if (prev_complete && $urandom_range(0, 3) == 0) drive_byte(1'b0, 8'($urandom));
      for (int i = 0; i < k; i++) begin
        while ($urandom_range(0, 1) == 1) begin
          cam_sof = 1'($urandom); cam_pixel = 8'($urandom);
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        cam_sof = 1'b0;
        if (i == 0) frame_bytes = 16'(size);
        out_ready = ($urandom_range(0, 3) != 0);
        drive_byte(i == 0, pix[i]);
        frame_bytes = 16'($urandom);
      end
      model_frame(k, size);
      prev_complete = (k == size);
      if (k == size) begin
        exp_fc++; exp_done++;
        exp_csum = 0;
        for (int i = 0; i < k; i++) exp_csum = exp_csum + 16'(pix[i]);
      end else begin
        aborted_any = 1;
      end
    end
    drain();
    check("rnd_nwords", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("rnd_word", got_q[i], exp_q[i]);
    check("rnd_count", frame_count, 16'(exp_fc));
    check("rnd_done_cnt", done_cnt - d0, exp_done);
    check("rnd_short", short_frame, aborted_any);
    check("rnd_overflow", overflow, 0);
`ifdef CAM_PACKER_CSUM_EN
    check("rnd_csum", frame_csum, exp_csum);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cam_pixel_packer.md
# cam_pixel_packer

Camera ingress stage feeding the frame DMA. Accepts the 8-bit camera pixel stream (`cam_valid`/`cam_sof`/`cam_pixel`), tracks frame boundaries against a programmed frame size, and packs bytes little-endian into 32-bit words. Words are buffered in a small FIFO and presented to the DMA over a valid/ready interface with byte enables and an end-of-frame marker. It also supplies the frame counter and the overflow status bit for the CSR block.

## Interface
- `FIFO_DEPTH`, 8, word FIFO depth; power of two, ≥2.
- `CNT_W`, 16, width of the frame-size, byte and frame counters.

Reset is synchronous, active-high (`rst`); single clock `clk`.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `en`  in  1  capture enable (CSR cam_en)
- `frame_bytes`  in  CNT_W  expected bytes per frame; sampled at SOF
- `cam_valid`  in  1  pixel strobe
- `cam_sof`  in  1  first pixel of frame; qualified by `cam_valid`
- `cam_pixel`  in  8  pixel byte
- `out_valid`  out  1  FIFO head word valid
- `out_ready`  in  1  DMA accepts head word
- `out_data`  out  32  packed word; byte k = pixel 4n+k
- `out_be`  out  4  valid lanes of `out_data`
- `out_last`  out  1  word ends a frame
- `frame_done`  out  1  one-cycle pulse at frame completion
- `frame_count`  out  CNT_W  completed frames, wraps
- `overflow`  out  1  sticky: a word was dropped on a full FIFO
- `short_frame`  out  1  sticky: a frame was aborted by an early SOF
- `status_clr`  in  1  clears `overflow` and `short_frame`
- `busy`  out  1  state is CAPTURE
- `frame_csum`  out  16  only with `CAM_PACKER_CSUM_EN`

## Operation
- States: IDLE, CAPTURE.
- IDLE → CAPTURE when `en & cam_valid & cam_sof & frame_bytes != 0`.
  - Latch `frame_bytes` as `size`.
  - Clear `byte_cnt`.
  - Write the byte to lane 0.
- A SOF while `frame_bytes == 0` is ignored. Non-SOF bytes in IDLE are dropped.
- CAPTURE: each `cam_valid` byte goes to lane `byte_cnt[1:0]`, then `byte_cnt++`.
- A word is pushed when lane 3 is written, or when the byte is the last of the frame (`byte_cnt+1 == size`).
  - Push fields: `be` = lanes filled; `last` = end of frame.
- End of frame: push with `last=1`, pulse `frame_done`, increment `frame_count` (wraps), → IDLE.
  - Example: `size=6` gives word0 `be=F`, then word1 `be=3, last=1`.
- SOF during CAPTURE aborts the current frame:
  - Push the partial word with `last=1` and `be` = lanes filled; `be=0` if the previous word was full.
  - Set `short_frame`. Do not increment `frame_count`. Do not pulse `frame_done`.
  - The SOF byte starts the new frame in lane 0 in the same cycle.
- `en` low during CAPTURE: partial word discarded, → IDLE. FIFO contents are kept.
- Push when full:
  - If `out_ready & out_valid` in the same cycle, the push succeeds.
  - Otherwise the word is dropped, `overflow` is set, and byte counting continues.
- Sticky bits: set has priority over `status_clr` in the same cycle.

## Timing
- Byte accepted in cycle N with a push: `out_valid` high from cycle N+1 (registered FIFO, first-word fall-through).
- `frame_done` and the `frame_count` update occur in cycle N+1 after the final byte.
- Handshake: a word is consumed on `out_valid & out_ready`.
  - `out_data`, `out_be`, `out_last` are stable while `out_valid & !out_ready`.
- Full throughput: one byte per cycle sustained, and one word per cycle drained.
- Reset values:
  - State IDLE; FIFO empty.
  - `out_valid`, `out_data`, `out_be`, `out_last`, `frame_done`, `frame_count`, `overflow`, `short_frame`, `busy`, `frame_csum` all 0.
- Reset mid-frame: everything is discarded, including the FIFO.

## Configuration
- `CAM_PACKER_CSUM_EN` defined:
  - 16-bit wrapping sum of all accepted bytes of the frame, cleared at SOF.
  - Latched to `frame_csum` in the `frame_done` cycle.
  - Aborted frames do not update `frame_csum`.
- Undefined: `frame_csum` port and sum logic are absent; no other behaviour changes.

## Structure
- `dashcam_pkg` holds:
  - state enum `cam_pack_state_e` (IDLE, CAPTURE);
  - `CAM_WORD_W = 32`;
  - FIFO entry struct `{data[31:0], be[3:0], last}`.
- Sub-module `cam_word_fifo`: synchronous FWFT FIFO of entry structs, with full/empty flags.

## Test plan
- 64-byte frame, pixels 0..63, `out_ready=1` → 16 words, word0 = 0x03020100, word15 = 0x3F3E3D3C with `be=F, last=1`; `frame_count=1`; one `frame_done` pulse.
- `frame_bytes=6`, bytes A0..A5 → 0xA3A2A1A0 `be=F`, then 0x0000A5A4 `be=3 last=1`.
- SOF after 5 bytes of a 64-byte frame → pushed word `be=1 last=1`; `short_frame=1`; `frame_count` unchanged; new frame completes normally → count +1.
- `out_ready=0`, `FIFO_DEPTH=8`, 64-byte frame → 8 words held, `overflow=1`, `frame_count=1`; `status_clr` → `overflow=0`.
- `en` dropped after 10 bytes, then a 4-byte frame with `frame_bytes=4` → only 2 full words from the aborted frame remain, followed by 1 word `last=1`; `busy` low after abort.
- With `CAM_PACKER_CSUM_EN`: 64-byte frame 0..63 → `frame_csum = 2016` (0x07E0).
